// File: rtl/ltu_clk_div_detect_pkg.sv
// Shared definitions for the LTU divided-clock detector: counter width,
// FSM encoding and the divide-code <-> period mapping.
package ltu_clk_div_detect_pkg;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Code 0..3 selects a period of 2, 4, 8 or 16 clk cycles.
  function automatic logic [CNT_W-1:0] code_to_period(input logic [1:0] code);
    return CNT_W'(2) << code;
  endfunction

  function automatic logic period_legal(input logic [CNT_W-1:0] period);
    return (period == CNT_W'(2)) || (period == CNT_W'(4)) ||
           (period == CNT_W'(8)) || (period == CNT_W'(16));
  endfunction

  function automatic logic [1:0] period_code(input logic [CNT_W-1:0] period);
    logic [1:0] code;
    case (period)
      CNT_W'(4):  code = 2'd1;
      CNT_W'(8):  code = 2'd2;
      CNT_W'(16): code = 2'd3;
      default:    code = 2'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ltu_clk_div_detect_period_meas.sv
// Rising-edge detector and saturating period counter for the divided clock.
// period_o is the cycle count since the previous rise, valid when rise_o is high.
module ltu_period_meas
  import ltu_clk_div_detect_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_i,
  output logic             rise_o,
  output logic [CNT_W-1:0] period_o
);

  logic             div_q;
  logic             primed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The first sample after reset release only primes div_q; it is never a rise.
  assign rise_o   = div_i & ~div_q & primed_q;
  assign period_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rise_o) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q    <= 1'b0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      div_q    <= div_i;
      primed_q <= 1'b1;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ltu_clk_div_detect.sv
// Detects the divide ratio of LTUCLKDIVIN and locks once the same legal
// period has repeated STABLE_CNT times after the candidate was first seen.
module ltu_clk_div_detect
  import ltu_clk_div_detect_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LTUCLKDIVIN,
  output logic [1:0] LTUCLKDIVDET,
  output logic       LTUCLKDIVLOCK,
  output logic       LTUCLKDIVERR,
  output state_e     dbg_state_o
);

  localparam int MW = $clog2(STABLE_CNT + 2);
  localparam logic [MW-1:0]    LOCK_RUN = MW'(STABLE_CNT);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);

  logic             rise;
  logic [CNT_W-1:0] period;
  logic             legal;
  logic [1:0]       code;
  logic             timeout;

  state_e        state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic [MW-1:0] match_q, match_d;
  logic [1:0]    det_q, det_d;
  logic          lock_q, lock_d;
  logic          err_q, err_d;

  ltu_period_meas u_meas (
    .clk_i    (clk),
    .rst_i    (reset),
    .div_i    (LTUCLKDIVIN),
    .rise_o   (rise),
    .period_o (period)
  );

  assign legal   = period_legal(period);
  assign code    = period_code(period);
  assign timeout = ~rise && (period >= TO_CNT);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    det_d   = det_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
          match_d = '0;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          if (!legal) begin
            match_d = '0;
            err_d   = 1'b1;
          end else if (code == cand_q) begin
            // match_q counts periods already seen at this rate; this one completes the run.
            match_d = match_q + MW'(1);
            if (match_q == LOCK_RUN) begin
              state_d = ST_LOCKED;
              det_d   = cand_q;
              lock_d  = 1'b1;
            end
          end else begin
            cand_d  = code;
            match_d = MW'(1);
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          match_d = '0;
          lock_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          if (period != code_to_period(det_q)) begin
            state_d = ST_MEASURE;
            lock_d  = 1'b0;
            err_d   = 1'b1;
            if (legal) begin
              cand_d  = code;
              match_d = MW'(1);
            end else begin
              match_d = '0;
            end
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          match_d = '0;
          lock_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        lock_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      match_q <= '0;
      det_q   <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      det_q   <= det_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign LTUCLKDIVDET  = det_q;
  assign LTUCLKDIVLOCK = lock_q;
  assign LTUCLKDIVERR  = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ltu_clk_div_detect.sv
// Randomized and directed bench for ltu_clk_div_detect with a per-cycle
// scoreboard fed by a reference model built on rise timestamps.
module tb_ltu_clk_div_detect;
  import ltu_clk_div_detect_pkg::*;

  localparam int STABLE_CNT = 3;
  localparam int TIMEOUT    = 40;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic [1:0] det;
  logic       lock;
  logic       err;
  state_e     dbg_state;

  always #8 clk = ~clk;

  ltu_clk_div_detect #(
    .STABLE_CNT (STABLE_CNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .LTUCLKDIVIN   (din),
    .LTUCLKDIVDET  (det),
    .LTUCLKDIVLOCK (lock),
    .LTUCLKDIVERR  (err),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         err_seen = 0;
  string      scen = "reset";

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Expected word layout: {state[1:0], det[1:0], lock, err}
  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (err) err_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({scen, "_cycle"}, int'({dbg_state, det, lock, err}), int'(e));
      end
    end
  end

  // ---------------- reference model ----------------
  // Time-based: the period of a rise is the distance in cycles to the previous
  // rise (or to the first edge after reset), capped at 63.
  int m_cyc = 0;
  int m_origin = 1;
  int m_mode = 0;   // 0 idle, 1 measuring, 2 locked
  int m_cand = 0;
  int m_run = 0;    // periods seen in a row at the candidate rate
  int m_det = 0;
  bit m_lock = 0;
  bit m_err = 0;
  bit m_prev = 0;
  bit m_primed = 0;

  task automatic model_edge(input bit rst_v, input bit d);
    int el;
    int code;
    bit rise;
    bit legal;
    m_cyc++;
    if (rst_v) begin
      m_mode = 0; m_cand = 0; m_run = 0; m_det = 0;
      m_lock = 0; m_err = 0; m_prev = 0; m_primed = 0;
      m_origin = m_cyc + 1;
    end else begin
      el = m_cyc - m_origin;
      if (el > 63) el = 63;
      rise = m_primed && d && !m_prev;
      m_prev = d;
      m_primed = 1;
      m_err = 0;
      legal = (el == 2) || (el == 4) || (el == 8) || (el == 16);
      code = legal ? $clog2(el) - 1 : 0;
      if (rise) begin
        m_origin = m_cyc;
        if (m_mode == 0) begin
          m_mode = 1;
          m_run = 0;
        end else if (m_mode == 1) begin
          if (!legal) begin
            m_run = 0;
            m_err = 1;
          end else begin
            if (code == m_cand) m_run++;
            else begin
              m_cand = code;
              m_run = 1;
            end
            if (m_run == STABLE_CNT + 1) begin
              m_mode = 2;
              m_det = m_cand;
              m_lock = 1;
            end
          end
        end else if (el != (2 << m_det)) begin
          m_mode = 1;
          m_lock = 0;
          m_err = 1;
          if (legal) begin
            m_cand = code;
            m_run = 1;
          end else begin
            m_run = 0;
          end
        end
      end else if (m_mode != 0 && el >= TIMEOUT) begin
        m_mode = 0;
        m_lock = 0;
        m_err = 1;
      end
    end
    exp_q.push_back({2'(m_mode), 2'(m_det), m_lock, m_err});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit rst_v, input bit d);
    @(negedge clk);
    if (rst_v && !reset) begin
      reset = 1'b1;
      #1;
      check({scen, "_async_reset"}, int'({dbg_state, det, lock, err}), 0);
    end
    reset = rst_v;
    din = d;
    model_edge(rst_v, d);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (hi) step(1'b0, 1'b1);
      repeat (lo) step(1'b0, 1'b0);
    end
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) step(1'b0, v);
  endtask

  task automatic reset_for(input int n);
    repeat (n) step(1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic expect_out(input string name, input int lock_e, input int det_e);
    check({name, "_lock"}, int'(lock), lock_e);
    if (lock_e == 1) check({name, "_det"}, int'(det), det_e);
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int kind;
    int c;
    int p;
    int h;
    reset_for(4);
    check("reset_state", int'({dbg_state, det, lock, err}), 0);

    scen = "div2"; err_seen = 0;
    wave(1, 1, 20);
    expect_out("div2", 1, 0);
    check("div2_err_count", err_seen, 0);

    scen = "div16_to_div4"; err_seen = 0;
    wave(8, 8, 6);
    expect_out("div16", 1, 3);
    wave(2, 2, 8);
    expect_out("div4_relock", 1, 1);
    check("div16_to_div4_err_count", err_seen, 2);

    scen = "illegal6";
    reset_for(3);
    err_seen = 0;
    wave(3, 3, 8);
    expect_out("illegal6", 0, 0);
    check("illegal6_err_count", err_seen, 6);

    scen = "timeout";
    reset_for(2);
    wave(4, 4, 8);
    expect_out("div8", 1, 2);
    err_seen = 0;
    hold(1'b0, 60);
    expect_out("timeout", 0, 0);
    check("timeout_err_count", err_seen, 1);
    check("timeout_state_idle", int'(dbg_state), int'(ST_IDLE));

    scen = "reset_locked";
    wave(2, 2, 8);
    expect_out("div4_pre_reset", 1, 1);
    reset_for(3);
    check("reset_outputs_zero", int'({det, lock, err}), 0);
    wave(2, 2, 8);
    expect_out("div4_post_reset", 1, 1);

    scen = "sweep";
    for (int k = 0; k < 4; k++) begin
      h = 1 << k;
      wave(h, h, 96 / (2 * h));
      expect_out($sformatf("sweep_code%0d", k), 1, k);
    end

    scen = "random";
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        c = $urandom_range(0, 3);
        wave(1 << c, 1 << c, $urandom_range(2, 8));
      end else if (kind <= 5) begin
        c = $urandom_range(0, 3);
        p = 2 << c;
        h = $urandom_range(1, p - 1);
        wave(h, p - h, $urandom_range(2, 7));
      end else if (kind <= 7) begin
        wave($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 6));
      end else if (kind == 8) begin
        hold(1'($urandom_range(0, 1)), $urandom_range(5, 60));
      end else begin
        reset_for($urandom_range(1, 3));
      end
    end

    scen = "drain";
    hold(1'b0, 3);
    @(posedge clk);
    #2;
    check("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
